// File: rtl/hv_lbist_pkg.sv
// Shared types and width helpers for the HV logic-BIST sequencer.
package hv_lbist_pkg;

   localparam int unsigned CLK_M = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_OWT  = 2'd2,
      ST_DONE = 2'd3
   } lbist_state_t;

   function automatic int unsigned reg_cnt_w(input int unsigned reg_num);
      return $clog2(reg_num + 1);
   endfunction

   function automatic int unsigned err_cnt_w(input int unsigned ch_num, input int unsigned reg_num);
      return $clog2(ch_num * reg_num + 1);
   endfunction

   function automatic int unsigned owt_cnt_w(input int unsigned th);
      return $clog2(th + 1);
   endfunction

   function automatic int unsigned ch_w(input int unsigned ch_num);
      return (ch_num > 1) ? $clog2(ch_num) : 1;
   endfunction

endpackage

// File: rtl/hv_bist_tmr.sv
// Saturating run timer shared by HV self-tests; expires at TMO_CYC-1 and holds there.
module hv_bist_tmr #(
   parameter int unsigned TMO_CYC = 25000,
   localparam int unsigned CNT_W  = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired_c
);

   logic [CNT_W-1:0] cnt;

   assign o_expired_c = (cnt == CNT_W'(TMO_CYC - 1));

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt <= '0;
      end else if (i_clr) begin
         cnt <= '0;
      end else if (i_en && !o_expired_c) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/hv_lbist_mc.sv
// Multi-channel logic-BIST sequencer: serial scan req/ack walk, parallel OWT frame
// counting and a bounded run window, reporting per-channel and OWT verdicts.
module hv_lbist_mc
   import hv_lbist_pkg::*;
#(
   parameter int unsigned SCAN_CH_NUM  = 2,
   parameter int unsigned SCAN_REG_NUM = 8,
   parameter int unsigned OWT_RX_OK_TH = 3,
   parameter int unsigned TMO_CYC      = 25000 * CLK_M,
   localparam int unsigned ERR_CNT_W   = err_cnt_w(SCAN_CH_NUM, SCAN_REG_NUM)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_bist_en,
   output logic [SCAN_CH_NUM-1:0] o_scan_req,
   input  logic [SCAN_CH_NUM-1:0] i_scan_ack,
   input  logic [SCAN_CH_NUM-1:0] i_scan_err,
   input  logic                   i_owt_rx_ack,
   input  logic                   i_owt_rx_status,
   output logic [SCAN_CH_NUM-1:0] o_scan_rult,
   output logic [ERR_CNT_W-1:0]   o_scan_err_cnt,
   output logic                   o_owt_rult,
   output logic                   o_bist_tmo,
   output logic                   o_bist_busy,
   output logic                   o_bist_done
);

   localparam int unsigned REG_CNT_W = reg_cnt_w(SCAN_REG_NUM);
   localparam int unsigned CH_W      = ch_w(SCAN_CH_NUM);
   localparam int unsigned OWT_CNT_W = owt_cnt_w(OWT_RX_OK_TH);

   lbist_state_t           state, state_nxt;
   logic                   en_d;
   logic [CH_W-1:0]        ch, ch_nxt;
   logic [REG_CNT_W-1:0]   reg_cnt, reg_cnt_nxt;
   logic [OWT_CNT_W-1:0]   owt_cnt, owt_cnt_nxt;
   logic [ERR_CNT_W-1:0]   err_cnt_nxt;
   logic [SCAN_CH_NUM-1:0] req_nxt, rult_nxt;
   logic                   owt_rult_nxt, tmo_flag_nxt;

   logic start, run, tmr_clr, tmo_exp_c;
   logic ack_hit, err_hit, ch_done, ch_last, owt_frame_ok;

   assign start        = i_bist_en & ~en_d;
   assign run          = (state == ST_SCAN) || (state == ST_OWT);
   assign tmr_clr      = (state == ST_IDLE) && start;
   assign ack_hit      = (state == ST_SCAN) && o_scan_req[ch] && i_scan_ack[ch];
   assign err_hit      = ack_hit && i_scan_err[ch];
   assign ch_done      = ack_hit && (reg_cnt == REG_CNT_W'(SCAN_REG_NUM - 1));
   assign ch_last      = (ch == CH_W'(SCAN_CH_NUM - 1));
   assign owt_frame_ok = i_owt_rx_ack && !i_owt_rx_status;

   hv_bist_tmr #(
      .TMO_CYC (TMO_CYC)
   ) u_tmr (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_clr       (tmr_clr),
      .i_en        (run),
      .o_expired_c (tmo_exp_c)
   );

   // Next-state and next-output decode
   always_comb begin
      state_nxt    = state;
      ch_nxt       = ch;
      reg_cnt_nxt  = reg_cnt;
      owt_cnt_nxt  = owt_cnt;
      err_cnt_nxt  = o_scan_err_cnt;
      rult_nxt     = o_scan_rult;
      req_nxt      = '0;
      owt_rult_nxt = o_owt_rult;
      tmo_flag_nxt = o_bist_tmo;

      case (state)
         ST_IDLE: begin
            if (start) begin
               state_nxt    = ST_SCAN;
               ch_nxt       = '0;
               reg_cnt_nxt  = '0;
               owt_cnt_nxt  = '0;
               err_cnt_nxt  = '0;
               rult_nxt     = '1;
               owt_rult_nxt = 1'b0;
               tmo_flag_nxt = 1'b0;
               req_nxt      = SCAN_CH_NUM'(1);
            end
         end
         ST_SCAN, ST_OWT: begin
            if (owt_frame_ok && (owt_cnt < OWT_CNT_W'(OWT_RX_OK_TH))) begin
               owt_cnt_nxt = owt_cnt + 1'b1;
            end
            if (ack_hit) begin
               if (ch_done) begin
                  reg_cnt_nxt = '0;
                  if (!ch_last) ch_nxt = ch + 1'b1;
               end else begin
                  reg_cnt_nxt = reg_cnt + 1'b1;
               end
               if (err_hit) begin
                  rult_nxt[ch] = 1'b0;
                  if (o_scan_err_cnt != '1) err_cnt_nxt = o_scan_err_cnt + 1'b1;
               end
            end
            if ((state == ST_SCAN) && ch_done && ch_last) state_nxt = ST_OWT;
            if ((state == ST_OWT) && (owt_cnt >= OWT_CNT_W'(OWT_RX_OK_TH))) state_nxt = ST_DONE;
            // Timeout fails every channel still short of its acks (after this cycle's ack)
            if (tmo_exp_c) begin
               state_nxt    = ST_DONE;
               tmo_flag_nxt = 1'b1;
               if (state == ST_SCAN) begin
                  for (int unsigned i = 0; i < SCAN_CH_NUM; i++) begin
                     if ((CH_W'(i) > ch) || ((CH_W'(i) == ch) && !ch_done)) rult_nxt[i] = 1'b0;
                  end
               end
            end
            if ((state_nxt == ST_SCAN) && !ack_hit) begin
               if (|o_scan_req) begin
                  req_nxt = o_scan_req;
               end else if (reg_cnt < REG_CNT_W'(SCAN_REG_NUM)) begin
                  req_nxt = SCAN_CH_NUM'(1) << ch;
               end
            end
            if (state_nxt == ST_DONE) begin
               owt_rult_nxt = (owt_cnt_nxt >= OWT_CNT_W'(OWT_RX_OK_TH));
            end
            if (!i_bist_en) begin
               state_nxt    = ST_IDLE;
               req_nxt      = '0;
               rult_nxt     = '0;
               owt_rult_nxt = 1'b0;
               err_cnt_nxt  = o_scan_err_cnt;
               tmo_flag_nxt = o_bist_tmo;
            end
         end
         ST_DONE: state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state          <= ST_IDLE;
         en_d           <= 1'b0;
         ch             <= '0;
         reg_cnt        <= '0;
         owt_cnt        <= '0;
         o_scan_req     <= '0;
         o_scan_rult    <= '0;
         o_scan_err_cnt <= '0;
         o_owt_rult     <= 1'b0;
         o_bist_tmo     <= 1'b0;
         o_bist_busy    <= 1'b0;
         o_bist_done    <= 1'b0;
      end else begin
         state          <= state_nxt;
         en_d           <= i_bist_en;
         ch             <= ch_nxt;
         reg_cnt        <= reg_cnt_nxt;
         owt_cnt        <= owt_cnt_nxt;
         o_scan_req     <= req_nxt;
         o_scan_rult    <= rult_nxt;
         o_scan_err_cnt <= err_cnt_nxt;
         o_owt_rult     <= owt_rult_nxt;
         o_bist_tmo     <= tmo_flag_nxt;
         o_bist_busy    <= (state_nxt != ST_IDLE);
         o_bist_done    <= (state_nxt == ST_DONE);
      end
   end

endmodule

// File: tb/tb_hv_lbist_mc.sv
// Scoreboard bench for hv_lbist_mc: expected run verdicts are queued at start and
// checked by a monitor on every done pulse; an automatic responder answers scan requests.
module tb_hv_lbist_mc;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [1:0] req;
   logic [1:0] ack;
   logic [1:0] err;
   logic       owt_ack;
   logic       owt_st;
   logic [1:0] rult;
   logic [2:0] err_cnt;
   logic       owt_rult;
   logic       tmo;
   logic       busy;
   logic       done;

   hv_lbist_mc #(
      .SCAN_CH_NUM  (2),
      .SCAN_REG_NUM (3),
      .OWT_RX_OK_TH (3),
      .TMO_CYC      (200)
   ) dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_bist_en       (en),
      .o_scan_req      (req),
      .i_scan_ack      (ack),
      .i_scan_err      (err),
      .i_owt_rx_ack    (owt_ack),
      .i_owt_rx_status (owt_st),
      .o_scan_rult     (rult),
      .o_scan_err_cnt  (err_cnt),
      .o_owt_rult      (owt_rult),
      .o_bist_tmo      (tmo),
      .o_bist_busy     (busy),
      .o_bist_done     (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] rult;
      logic [2:0] err_cnt;
      logic       owt;
      logic       tmo;
      int         done_cyc;
   } exp_t;

   exp_t       exp_q[$];
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         done_cnt = 0;
   int         done_base = 0;
   int         resp_mode = 0;
   bit   [1:0] ack_en = 2'b11;
   int         ack_n[2];
   int         err_at[2];
   int         ack_log[$];
   bit         onehot_bad = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, expv, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Scan responder: zero-wait ack, optional error on a chosen ack number
   always @(negedge clk) begin
      case (resp_mode)
         1: begin
            for (int c = 0; c < 2; c++) begin
               if (ack_en[c] && req[c] && !ack[c]) begin
                  ack[c] = 1'b1;
                  ack_n[c]++;
                  err[c] = (ack_n[c] == err_at[c]);
                  ack_log.push_back(c);
               end else begin
                  ack[c] = 1'b0;
                  err[c] = 1'b0;
               end
            end
         end
         2: begin
            ack = 2'b11;
            err = 2'b11;
         end
         default: begin
            ack = 2'b00;
            err = 2'b00;
         end
      endcase
   end

   // Monitor: every done pulse must match the oldest queued expectation
   always @(negedge clk) begin : monitor
      exp_t e;
      if ($countones(req) > 1) onehot_bad = 1'b1;
      if (done === 1'b1) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done pulse at cycle %0d want none", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("rult", 32'(rult), 32'(e.rult));
            chk("err_cnt", 32'(err_cnt), 32'(e.err_cnt));
            chk("owt_rult", 32'(owt_rult), 32'(e.owt));
            chk("bist_tmo", 32'(tmo), 32'(e.tmo));
            chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_run(input bit push, input logic [1:0] r, input logic [2:0] ec,
                            input logic o, input logic t, input int dcyc);
      exp_t e;
      ack_n[0] = 0;
      ack_n[1] = 0;
      ack_log.delete();
      @(negedge clk);
      if (push) begin
         e.rult     = r;
         e.err_cnt  = ec;
         e.owt      = o;
         e.tmo      = t;
         e.done_cyc = cyc + dcyc;
         exp_q.push_back(e);
      end
      done_base = done_cnt;
      en = 1'b1;
   endtask

   task automatic send_frames(input int n, input logic [7:0] st);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         owt_ack = 1'b1;
         owt_st  = st[i];
         @(negedge clk);
         owt_ack = 1'b0;
         owt_st  = 1'b0;
      end
   endtask

   task automatic wait_done(input string name, input int budget);
      int k;
      k = 0;
      while ((done_cnt == done_base) && (k < budget)) begin
         @(negedge clk);
         k++;
      end
      chk(name, 32'(done_cnt > done_base), 32'd1);
   endtask

   task automatic end_run();
      @(negedge clk);
      en = 1'b0;
      tick(2);
   endtask

   initial begin : stim
      int code;
      rst     = 1'b1;
      en      = 1'b0;
      owt_ack = 1'b0;
      owt_st  = 1'b0;
      err_at[0] = 0;
      err_at[1] = 0;
      tick(3);
      chk("rst_req", 32'(req), 32'd0);
      chk("rst_rult", 32'(rult), 32'd0);
      chk("rst_err_cnt", 32'(err_cnt), 32'd0);
      chk("rst_owt", 32'(owt_rult), 32'd0);
      chk("rst_tmo", 32'(tmo), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      rst = 1'b0;
      tick(2);
      resp_mode = 1;

      // Clean pass: 6 regs x 2 cycles, OWT entered at +12, done at +13
      start_run(1'b1, 2'b11, 3'd0, 1'b1, 1'b0, 13);
      send_frames(3, 8'h00);
      wait_done("pass_done_seen", 300);
      tick(30);
      chk("rearm_busy", 32'(busy), 32'd0);
      end_run();

      // Channel 1 error on 2nd ack; 5 ok frames exercise OWT saturation
      err_at[1] = 2;
      start_run(1'b1, 2'b01, 3'd1, 1'b1, 1'b0, 13);
      send_frames(5, 8'h00);
      wait_done("cherr_done_seen", 300);
      code = 0;
      foreach (ack_log[i]) code = code | (ack_log[i] << i);
      chk("ack_count", 32'(ack_log.size()), 32'd6);
      chk("ack_order", 32'(code), 32'd56);
      err_at[1] = 0;
      end_run();

      // Timeout: channel 1 never answers
      ack_en = 2'b01;
      start_run(1'b1, 2'b01, 3'd0, 1'b1, 1'b1, 201);
      send_frames(3, 8'h00);
      wait_done("tmo_done_seen", 300);
      ack_en = 2'b11;
      end_run();

      // OWT shortfall: 2 ok + 5 error frames
      start_run(1'b1, 2'b11, 3'd0, 1'b0, 1'b1, 201);
      send_frames(7, 8'b0111_0110);
      wait_done("short_done_seen", 300);
      end_run();

      // Abort mid-SCAN after one errored ack on channel 0
      err_at[0] = 1;
      start_run(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 0);
      tick(4);
      en = 1'b0;
      tick(1);
      chk("abort_req", 32'(req), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_rult", 32'(rult), 32'd0);
      chk("abort_owt", 32'(owt_rult), 32'd0);
      chk("abort_err_cnt", 32'(err_cnt), 32'd1);
      chk("abort_done", 32'(done), 32'd0);
      tick(20);
      chk("abort_busy_late", 32'(busy), 32'd0);

      // Reset mid-run, then stray acks while idle
      start_run(1'b0, 2'b00, 3'd0, 1'b0, 1'b0, 0);
      tick(6);
      rst = 1'b1;
      en  = 1'b0;
      tick(1);
      chk("mrst_req", 32'(req), 32'd0);
      chk("mrst_rult", 32'(rult), 32'd0);
      chk("mrst_err_cnt", 32'(err_cnt), 32'd0);
      chk("mrst_busy", 32'(busy), 32'd0);
      chk("mrst_done", 32'(done), 32'd0);
      rst = 1'b0;
      err_at[0] = 0;
      resp_mode = 2;
      tick(4);
      resp_mode = 0;
      tick(1);
      chk("stray_req", 32'(req), 32'd0);
      chk("stray_busy", 32'(busy), 32'd0);
      chk("stray_err_cnt", 32'(err_cnt), 32'd0);
      chk("stray_rult", 32'(rult), 32'd0);

      chk("req_onehot", 32'(onehot_bad), 32'd0);
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: got no end of test want finish before 1ms");
      $fatal(1);
   end

endmodule

// File: doc/hv_lbist_mc.md
# hv_lbist_mc

Multi-channel logic-BIST sequencer for the HV digital domain. It walks SCAN_CH_NUM scan-register channels serially, running a req/ack handshake per register. In parallel it counts good OWT receive frames inside a bounded timeout window. It reports per-channel pass/fail, a saturating error count, the OWT verdict, a timeout flag and a one-cycle done pulse to the HV top-level test controller.

## Interface
- SCAN_CH_NUM, 2: number of scan-register channels (≥1)
- SCAN_REG_NUM, 8: registers per channel, i.e. acks required per channel (≥1)
- OWT_RX_OK_TH, 3: good OWT frames required for OWT pass (≥1)
- TMO_CYC, 25000*CLK_M: run timeout in i_clk cycles (CLK_M from hv_param.svh)
- i_clk  in  1  single block clock
- i_rst  in  1  synchronous, active-high reset
- i_bist_en  in  1  level enable; a rising edge starts a run, low aborts
- o_scan_req  out  SCAN_CH_NUM  one-hot scan request for the active channel
- i_scan_ack  in  SCAN_CH_NUM  per-channel ack (1-cycle pulse)
- i_scan_err  in  SCAN_CH_NUM  per-channel error, qualified by the matching ack bit
- i_owt_rx_ack  in  1  OWT frame-received strobe
- i_owt_rx_status  in  1  OWT frame status, 0=ok, 1=error
- o_scan_rult  out  SCAN_CH_NUM  per-channel result, 1=pass
- o_scan_err_cnt  out  ERR_CNT_W  total scan errors, saturating
- o_owt_rult  out  1  OWT result, 1=pass
- o_bist_tmo  out  1  last run ended by timeout
- o_bist_busy  out  1  run in progress
- o_bist_done  out  1  one-cycle completion pulse

## Operation
- Reset values: o_scan_req=0, o_scan_rult=0, o_scan_err_cnt=0, o_owt_rult=0, o_bist_tmo=0, o_bist_busy=0, o_bist_done=0, state=IDLE, all counters 0.
- **FSM states:** IDLE, SCAN, OWT, DONE.
- **IDLE:**
  - Start condition: i_bist_en & ~en_d, where en_d is i_bist_en registered by one cycle.
  - On start: o_scan_rult set to all ones, err/OWT/timeout counters cleared, o_bist_tmo=0, channel index ch=0, reg_cnt=0, go to SCAN.
- **SCAN:**
  - o_scan_req[ch] is registered. It asserts when reg_cnt<SCAN_REG_NUM and req is low, and holds until i_scan_ack[ch].
  - In the ack cycle: reg_cnt+1; if i_scan_err[ch]=1, clear o_scan_rult[ch] and increment o_scan_err_cnt (saturating at all ones). o_scan_req drops the next cycle.
  - Ack bits of inactive channels, and acks while req is low, are ignored.
  - When reg_cnt reaches SCAN_REG_NUM: ch+1 and reg_cnt=0. After the last channel, go to OWT.
- **OWT frame counting:** active in both SCAN and OWT. owt_cnt increments on i_owt_rx_ack & ~i_owt_rx_status and saturates at OWT_RX_OK_TH. Error frames are ignored.
- **OWT state:** when owt_cnt ≥ OWT_RX_OK_TH, go to DONE.
- **Timeout:**
  - tmo_cnt counts every cycle in SCAN/OWT and saturates at TMO_CYC-1.
  - On reaching TMO_CYC-1: go to DONE and set o_bist_tmo=1.
  - Channels not yet complete get o_scan_rult bit cleared. An ack arriving in the timeout cycle is still counted first.
- **DONE (one cycle):**
  - o_owt_rult = (owt_cnt ≥ OWT_RX_OK_TH).
  - o_bist_done=1 for this cycle, then go to IDLE.
  - Results hold until the next start.
- **Abort:**
  - i_bist_en=0 in SCAN or OWT: go to IDLE next cycle.
  - o_scan_req cleared, o_scan_rult=0, o_owt_rult=0, no done pulse.
  - o_scan_err_cnt holds its last value.
- **No re-arm:** i_bist_en held high after DONE does not restart a run; a new low→high edge is required.
- **Widths:** REG_CNT_W=$clog2(SCAN_REG_NUM+1), CH_W=$clog2(SCAN_CH_NUM) (minimum 1), ERR_CNT_W=$clog2(SCAN_CH_NUM*SCAN_REG_NUM+1), OWT_CNT_W=$clog2(OWT_RX_OK_TH+1), TMO_CNT_W=$clog2(TMO_CYC).

## Timing
- Start edge sampled in cycle N → state=SCAN, o_bist_busy=1 and o_scan_req[0]=1 in N+1.
- Ack in cycle M → req low in M+1, next req high in M+2. A zero-wait responder therefore costs 2 cycles per register.
- Terminal condition in cycle T → o_bist_done=1 and results valid in T+1; o_bist_busy=0 in T+2.
- Abort: i_bist_en low in cycle A → o_bist_busy=0 and o_scan_req=0 in A+1.
- i_rst overrides everything in the cycle it is sampled.

## Structure
- Package hv_lbist_pkg holds:
  - the state enum typedef
  - width helper functions for REG_CNT_W, ERR_CNT_W, OWT_CNT_W
- Sub-module hv_bist_tmr: parametrised saturating timeout counter (TMO_CYC) with clear/enable inputs and an expired output. It can be reused by other HV self-tests.

## Test plan
Common configuration: SCAN_CH_NUM=2, SCAN_REG_NUM=3, OWT_RX_OK_TH=3, TMO_CYC=200.
- **Clean pass:** zero-wait acks with no errors, 3 ok OWT frames → done at or before cycle 200; o_scan_rult=2'b11, o_owt_rult=1, o_bist_tmo=0, o_scan_err_cnt=0.
- **Channel error:** i_scan_err[1] asserted on its 2nd ack → o_scan_rult=2'b01, o_scan_err_cnt=1; req/ack ordering is ch0 ×3 then ch1 ×3.
- **Timeout:** ch1 never acks → done in cycle 201 after start; o_bist_tmo=1, o_scan_rult=2'b01, o_owt_rult reflects frames received.
- **OWT shortfall:** 2 ok frames and 5 error frames → timeout; o_owt_rult=0, owt_cnt never exceeds 3.
- **Abort:** drop i_bist_en mid-SCAN → o_scan_req=0 and busy=0 next cycle, no done pulse, results=0. Holding i_bist_en high after a completed run produces no second run.
- **Reset:** i_rst mid-run → all outputs at reset values next cycle; stray acks while IDLE are ignored.
